// File: rtl/sipo_deser_pkg.sv
// rtl/sipo_deser_pkg.sv - shared types and helpers for the sipo_deser deserialiser
// Optional parity support is selected with SIPO_DESER_PARITY_EN.
package sipo_deser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Upper bound on WIDTH supported by align_word.
  localparam int MAX_W = 64;

  function automatic int clamp_len(input int len, input int width);
    if (len == 0 || len > width) return width;
    return len;
  endfunction

  // Shifter holds arrival bit k at index k; MSB-first reverses the first n bits.
  function automatic logic [MAX_W-1:0] align_word(input logic [MAX_W-1:0] sh,
                                                  input int n,
                                                  input bit msb_first);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < n) r[i] = msb_first ? sh[n-1-i] : sh[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// rtl/sipo_hold_reg.sv - one-entry valid/ready holding register with drop report
// A load while full and not being accepted is dropped and flagged on drop_o.
module sipo_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             accept_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             drop_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && accept_i) valid_d = 1'b0;
    if (load_i && (!valid_q || accept_i)) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign drop_o  = load_i && valid_q && !accept_i;

endmodule

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - strobe-qualified serial-to-parallel deserialiser for UART RX
// Define SIPO_DESER_PARITY_EN to add a trailing parity bit and parity_err output.
module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             shift_en,
  input  logic             clear,
  input  logic [CNT_W-1:0] word_len,
  output logic [WIDTH-1:0] q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             overrun_clr
`ifdef SIPO_DESER_PARITY_EN
  ,
  input  logic             parity_odd,
  output logic             parity_err
`endif
);

`ifdef SIPO_DESER_PARITY_EN
  localparam int HOLD_W = WIDTH + 1;
  logic par_err_d;
`else
  localparam int HOLD_W = WIDTH;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d, len_q, len_d, len_in;
  logic [WIDTH-1:0] sh_q, sh_d, word_d;
  logic             data_done, complete;
  logic             overrun_q, overrun_d, drop;
  logic [HOLD_W-1:0] hold_in, hold_out;

  function automatic logic [MAX_W-1:0] widen(input logic [WIDTH-1:0] v);
    widen = '0;
    widen[WIDTH-1:0] = v;
  endfunction

  assign len_in = CNT_W'(clamp_len(int'(word_len), WIDTH));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    len_d     = len_q;
    sh_d      = sh_q;
    data_done = 1'b0;
    complete  = 1'b0;
    word_d    = '0;
`ifdef SIPO_DESER_PARITY_EN
    par_err_d = 1'b0;
`endif
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else if (shift_en) begin
      case (state_q)
        IDLE: begin
          sh_d      = '0;
          sh_d[0]   = data_in;
          len_d     = len_in;
          count_d   = CNT_W'(1);
          state_d   = SHIFT;
          data_done = (len_in == CNT_W'(1));
        end
        SHIFT: begin
          for (int i = 0; i < WIDTH; i++) begin
            if (i == int'(count_q)) sh_d[i] = data_in;
          end
          count_d   = count_q + CNT_W'(1);
          data_done = (count_d == len_q);
        end
`ifdef SIPO_DESER_PARITY_EN
        PARITY: begin
          complete  = 1'b1;
          state_d   = IDLE;
          count_d   = '0;
          word_d    = WIDTH'(align_word(widen(sh_q), int'(len_q), MSB_FIRST != 0));
          par_err_d = ((^sh_q) ^ data_in) != parity_odd;
        end
`endif
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end

    if (data_done) begin
`ifdef SIPO_DESER_PARITY_EN
      // Count stays at N so busy covers the pending parity bit.
      state_d = PARITY;
`else
      complete = 1'b1;
      state_d  = IDLE;
      count_d  = '0;
      word_d   = WIDTH'(align_word(widen(sh_d), int'(len_d), MSB_FIRST != 0));
`endif
    end
  end

`ifdef SIPO_DESER_PARITY_EN
  assign hold_in = {par_err_d, word_d};
`else
  assign hold_in = word_d;
`endif

  sipo_hold_reg #(
    .WIDTH(HOLD_W)
  ) u_hold (
    .clk     (clk),
    .reset   (reset),
    .load_i  (complete),
    .data_i  (hold_in),
    .accept_i(out_ready),
    .data_o  (hold_out),
    .valid_o (out_valid),
    .drop_o  (drop)
  );

  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (drop)        overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      len_q     <= '0;
      sh_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      len_q     <= len_d;
      sh_q      <= sh_d;
      overrun_q <= overrun_d;
    end
  end

  assign q       = hold_out[WIDTH-1:0];
  assign busy    = (count_q != '0);
  assign overrun = overrun_q;
`ifdef SIPO_DESER_PARITY_EN
  assign parity_err = hold_out[WIDTH] & out_valid;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - directed self-checking bench for sipo_deser (LSB- and MSB-first)
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       reset, data_in, shift_en, clear, out_ready, overrun_clr;
  logic [3:0] word_len;
  logic [7:0] q_l, q_m;
  logic       v_l, v_m, b_l, b_m, o_l, o_m;
  int         checks = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .shift_en(shift_en), .clear(clear),
    .word_len(word_len), .q(q_l), .out_valid(v_l), .out_ready(out_ready),
    .busy(b_l), .overrun(o_l), .overrun_clr(overrun_clr)
  );

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .shift_en(shift_en), .clear(clear),
    .word_len(word_len), .q(q_m), .out_valid(v_m), .out_ready(out_ready),
    .busy(b_m), .overrun(o_m), .overrun_clr(overrun_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    data_in  = b;
    shift_en = 1'b1;
    tick();
    shift_en = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int k = 0; k < 8; k++) send_bit(w[k]);
  endtask

  task automatic test_reset();
    #12;
    checks++; if (q_l !== 8'h00) $display("FAIL rst_q: got %h want 00", q_l); else passed++;
    checks++; if (v_l !== 1'b0) $display("FAIL rst_valid: got %b want 0", v_l); else passed++;
    checks++; if (b_l !== 1'b0) $display("FAIL rst_busy: got %b want 0", b_l); else passed++;
    checks++; if (o_l !== 1'b0) $display("FAIL rst_overrun: got %b want 0", o_l); else passed++;
    checks++; if (v_m !== 1'b0) $display("FAIL rst_valid_m: got %b want 0", v_m); else passed++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_lsb8();
    logic [7:0] w;
    w = 8'h4D;
    out_ready = 1'b1;
    word_len  = 4'd8;
    for (int k = 0; k < 7; k++) send_bit(w[k]);
    checks++; if (b_l !== 1'b1) $display("FAIL lsb8_busy_mid: got %b want 1", b_l); else passed++;
    checks++; if (v_l !== 1'b0) $display("FAIL lsb8_valid_early: got %b want 0", v_l); else passed++;
    send_bit(w[7]);
    checks++; if (v_l !== 1'b1) $display("FAIL lsb8_valid: got %b want 1", v_l); else passed++;
    checks++; if (q_l !== 8'h4D) $display("FAIL lsb8_q: got %h want 4d", q_l); else passed++;
    checks++; if (b_l !== 1'b0) $display("FAIL lsb8_busy_end: got %b want 0", b_l); else passed++;
    checks++; if (q_m !== 8'hB2) $display("FAIL msb8_q: got %h want b2", q_m); else passed++;
    tick();
    checks++; if (v_l !== 1'b0) $display("FAIL lsb8_consumed: got %b want 0", v_l); else passed++;
  endtask

  task automatic test_msb_len();
    logic [7:0] w;
    w = 8'h19;
    word_len = 4'd5;
    send_bit(w[0]);
    word_len = 4'd3;
    for (int k = 1; k < 5; k++) send_bit(w[k]);
    checks++; if (v_m !== 1'b1) $display("FAIL msb5_valid: got %b want 1", v_m); else passed++;
    checks++; if (q_m !== 8'h13) $display("FAIL msb5_q: got %h want 13", q_m); else passed++;
    checks++; if (q_l !== 8'h19) $display("FAIL lsb5_q: got %h want 19", q_l); else passed++;
    tick();
    word_len = 4'd0;
    w = 8'h83;
    for (int k = 0; k < 7; k++) send_bit(w[k]);
    checks++; if (b_m !== 1'b1) $display("FAIL len0_busy: got %b want 1", b_m); else passed++;
    checks++; if (v_m !== 1'b0) $display("FAIL len0_valid_early: got %b want 0", v_m); else passed++;
    send_bit(w[7]);
    checks++; if (q_m !== 8'hC1) $display("FAIL len0_q_m: got %h want c1", q_m); else passed++;
    checks++; if (q_l !== 8'h83) $display("FAIL len0_q_l: got %h want 83", q_l); else passed++;
    tick();
    word_len = 4'd8;
  endtask

  task automatic test_overrun();
    logic [7:0] w;
    out_ready = 1'b0;
    send_word(8'hA5);
    checks++; if (q_l !== 8'hA5) $display("FAIL ovr_first_q: got %h want a5", q_l); else passed++;
    checks++; if (o_l !== 1'b0) $display("FAIL ovr_none: got %b want 0", o_l); else passed++;
    send_word(8'h3C);
    checks++; if (q_l !== 8'hA5) $display("FAIL ovr_held_q: got %h want a5", q_l); else passed++;
    checks++; if (o_l !== 1'b1) $display("FAIL ovr_set: got %b want 1", o_l); else passed++;
    w = 8'h5A;
    for (int k = 0; k < 7; k++) send_bit(w[k]);
    out_ready = 1'b1;
    send_bit(w[7]);
    out_ready = 1'b0;
    checks++; if (v_l !== 1'b1) $display("FAIL ovr_swap_valid: got %b want 1", v_l); else passed++;
    checks++; if (q_l !== 8'h5A) $display("FAIL ovr_swap_q: got %h want 5a", q_l); else passed++;
    checks++; if (o_l !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", o_l); else passed++;
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    checks++; if (o_l !== 1'b0) $display("FAIL ovr_clr: got %b want 0", o_l); else passed++;
    checks++; if (v_l !== 1'b1) $display("FAIL ovr_hold: got %b want 1", v_l); else passed++;
    out_ready = 1'b1;
    tick();
    checks++; if (v_l !== 1'b0) $display("FAIL ovr_drain: got %b want 0", v_l); else passed++;
  endtask

  task automatic test_gaps_clear();
    logic [7:0] w;
    out_ready = 1'b0;
    send_word(8'h81);
    send_bit(1'b1);
    tick();
    tick();
    send_bit(1'b0);
    tick();
    send_bit(1'b1);
    checks++; if (b_l !== 1'b1) $display("FAIL clr_busy_pre: got %b want 1", b_l); else passed++;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (b_l !== 1'b0) $display("FAIL clr_busy: got %b want 0", b_l); else passed++;
    checks++; if (v_l !== 1'b1) $display("FAIL clr_valid: got %b want 1", v_l); else passed++;
    checks++; if (q_l !== 8'h81) $display("FAIL clr_q: got %h want 81", q_l); else passed++;
    checks++; if (o_l !== 1'b0) $display("FAIL clr_overrun: got %b want 0", o_l); else passed++;
    out_ready = 1'b1;
    tick();
    clear    = 1'b1;
    data_in  = 1'b1;
    shift_en = 1'b1;
    tick();
    clear    = 1'b0;
    shift_en = 1'b0;
    checks++; if (b_l !== 1'b0) $display("FAIL clr_shift_busy: got %b want 0", b_l); else passed++;
    w = 8'h6E;
    for (int k = 0; k < 8; k++) begin
      send_bit(w[k]);
      if (k < 7) tick();
    end
    checks++; if (v_l !== 1'b1) $display("FAIL gap_valid: got %b want 1", v_l); else passed++;
    checks++; if (q_l !== 8'h6E) $display("FAIL gap_q: got %h want 6e", q_l); else passed++;
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send_word(8'hF0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    checks++; if (b_l !== 1'b1) $display("FAIL ar_busy_pre: got %b want 1", b_l); else passed++;
    #3;
    reset = 1'b0;
    #1;
    checks++; if (q_l !== 8'h00) $display("FAIL ar_q: got %h want 00", q_l); else passed++;
    checks++; if (v_l !== 1'b0) $display("FAIL ar_valid: got %b want 0", v_l); else passed++;
    checks++; if (b_l !== 1'b0) $display("FAIL ar_busy: got %b want 0", b_l); else passed++;
    checks++; if (q_m !== 8'h00) $display("FAIL ar_q_m: got %h want 00", q_m); else passed++;
    #1;
    reset = 1'b1;
    tick();
    out_ready = 1'b1;
    send_word(8'h2B);
    checks++; if (v_l !== 1'b1) $display("FAIL ar_fresh_valid: got %b want 1", v_l); else passed++;
    checks++; if (q_l !== 8'h2B) $display("FAIL ar_fresh_q: got %h want 2b", q_l); else passed++;
    tick();
  endtask

  initial begin
    reset       = 1'b0;
    data_in     = 1'b0;
    shift_en    = 1'b0;
    clear       = 1'b0;
    out_ready   = 1'b0;
    overrun_clr = 1'b0;
    word_len    = 4'd8;
    test_reset();
    test_lsb8();
    test_msb_len();
    test_overrun();
    test_gaps_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
